// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, reps times, with zero-filled gaps between repetitions.
// Optional even-parity bit after each pattern when SEQ_PATTERN_GEN_PARITY_EN is defined.
module seq_pattern_gen #(
  parameter int PATTERN_W = 4,
  parameter int CNT_W     = 4,
  parameter int GAP_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [CNT_W-1:0]     reps,
  input  logic [GAP_W-1:0]     gap,
  output logic                 ready,
  output logic                 busy,
  output logic                 o,
  output logic                 o_valid,
  output logic                 done
);

  localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_GAP   = 3'd2,
    S_PAR   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic [CNT_W-1:0]     rep_left_q, rep_left_d;
  logic [GAP_W-1:0]     gap_len_q, gap_len_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 o_q, o_d;
  logic                 o_valid_q, o_valid_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pat_end;

  // Handshake: start is sampled only while ready is high (IDLE); a start
  // with reps==0 is dropped. There is no back-pressure on the serial side.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    rep_left_d = rep_left_q;
    gap_len_d  = gap_len_q;
    gap_cnt_d  = gap_cnt_q;
    bit_idx_d  = bit_idx_q;
    pat_end    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (reps != '0)) begin
          pattern_d  = pattern;
          rep_left_d = reps;
          gap_len_d  = gap;
          bit_idx_d  = LAST_IDX;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_idx_q == '0) begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
          state_d = S_PAR;
`else
          pat_end = 1'b1;
`endif
        end else begin
          bit_idx_d = bit_idx_q - 1'b1;
        end
      end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      S_PAR: pat_end = 1'b1;
`endif
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          bit_idx_d = LAST_IDX;
          state_d   = S_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // End of one repetition: finish, insert a gap, or restart back-to-back.
    if (pat_end) begin
      rep_left_d = rep_left_q - 1'b1;
      if (rep_left_q == CNT_W'(1)) begin
        state_d = S_DONE;
      end else if (gap_len_q != '0) begin
        gap_cnt_d = gap_len_q;
        state_d   = S_GAP;
      end else begin
        bit_idx_d = LAST_IDX;
        state_d   = S_SHIFT;
      end
    end

    // Outputs are decoded from the next state so they register in step with it.
    o_d = 1'b0;
    case (state_d)
      S_SHIFT: o_d = pattern_d[bit_idx_d];
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      S_PAR:   o_d = ^pattern_d;
`endif
      default: o_d = 1'b0;
    endcase
    o_valid_d = (state_d == S_SHIFT) || (state_d == S_GAP) || (state_d == S_PAR);
    busy_d    = o_valid_d;
    done_d    = (state_d == S_DONE);
    ready_d   = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pattern_q  <= '0;
      rep_left_q <= '0;
      gap_len_q  <= '0;
      gap_cnt_q  <= '0;
      bit_idx_q  <= '0;
      o_q        <= 1'b0;
      o_valid_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      rep_left_q <= rep_left_d;
      gap_len_q  <= gap_len_d;
      gap_cnt_q  <= gap_cnt_d;
      bit_idx_q  <= bit_idx_d;
      o_q        <= o_d;
      o_valid_q  <= o_valid_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: directed scenarios plus random transfers checked against a stream model.
// Define SEQ_PATTERN_GEN_PARITY_EN for both files to cover the parity build.
module tb_seq_pattern_gen;

  localparam int PW = 4;
  localparam int CW = 4;
  localparam int GW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PW-1:0] pattern;
  logic [CW-1:0] reps;
  logic [GW-1:0] gap;
  logic          ready, busy, o, o_valid, done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [0:0]  exp_q[$];

  seq_pattern_gen #(.PATTERN_W(PW), .CNT_W(CW), .GAP_W(GW)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps), .gap(gap),
    .ready(ready), .busy(busy), .o(o), .o_valid(o_valid), .done(done)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- checking ----
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ready"},   32'(ready),   32'd1);
    check({tag, ".busy"},    32'(busy),    32'd0);
    check({tag, ".o_valid"}, 32'(o_valid), 32'd0);
    check({tag, ".o"},       32'(o),       32'd0);
    check({tag, ".done"},    32'(done),    32'd0);
  endtask

  // Reference stream: reps copies of the pattern (MSB first, optional parity),
  // separated by gap zeros, with no trailing gap.
  task automatic build_stream(input logic [PW-1:0] p, input int r, input int g);
    exp_q.delete();
    for (int k = 0; k < r; k++) begin
      for (int b = PW - 1; b >= 0; b--) exp_q.push_back(p[b]);
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      exp_q.push_back(^p);
`endif
      if (k != r - 1) for (int z = 0; z < g; z++) exp_q.push_back(1'b0);
    end
  endtask

  // ---- drivers ----
  // Issues start on one edge, then walks the expected stream cycle by cycle.
  // noise=1 scrambles inputs and pulses start while the transfer is running.
  task automatic run_xfer(input string tag, input logic [PW-1:0] p, input int r,
                          input int g, input bit noise);
    int len;
    check({tag, ".pre_ready"}, 32'(ready), 32'd1);
    start = 1'b1; pattern = p; reps = CW'(r); gap = GW'(g);
    build_stream(p, r, g);
    len = exp_q.size();
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      check({tag, ".o_valid"}, 32'(o_valid), 32'd1);
      check({tag, ".o"},       32'(o),       32'(exp_q[i]));
      check({tag, ".busy"},    32'(busy),    32'd1);
      check({tag, ".done"},    32'(done),    32'd0);
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        pattern = (i == 0) ? '0 : PW'($urandom);
        reps    = CW'($urandom);
        gap     = GW'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, ".done"},       32'(done),    32'd1);
    check({tag, ".done_valid"}, 32'(o_valid), 32'd0);
    check({tag, ".done_ready"}, 32'(ready),   32'd0);
    check({tag, ".done_busy"},  32'(busy),    32'd0);
    @(negedge clk);
    check_idle({tag, ".after"});
  endtask

  // ---- stimulus ----
  initial begin
    rst = 1'b1; start = 1'b1; pattern = 4'b1101; reps = 4'd1; gap = '0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset_hold");
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("reset_release");
    end

    run_xfer("single",  4'b1101, 1, 0, 1'b0);
    run_xfer("overlap", 4'b1101, 2, 0, 1'b1);
    run_xfer("gapped",  4'b1101, 3, 2, 1'b0);

    start = 1'b1; pattern = 4'b1111; reps = '0; gap = 3'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle("reps_zero");
      @(negedge clk);
    end

    // Abort during the third stream bit of a single-pattern transfer.
    start = 1'b1; pattern = 4'b1101; reps = 4'd1; gap = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort.bit2", 32'(o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("abort");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("abort_quiet");
    end
    run_xfer("post_abort", 4'b1101, 1, 0, 1'b0);

    run_xfer("max_reps_gap", 4'b1011, (1 << CW) - 1, (1 << GW) - 1, 1'b1);

    for (int t = 0; t < 20; t++) begin
      run_xfer("random", PW'($urandom), int'($urandom_range(1, (1 << CW) - 1)),
               int'($urandom_range(0, (1 << GW) - 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial pattern transmitter, the stimulus-side counterpart of the Moore "1101" sequence detector.
- Accepts a parallel pattern, a repetition count and an inter-pattern gap length.
- Emits the stream MSB-first, one bit per clock, on a single serial output that drives a detector's serial input `i`.
- Supports back-to-back repetitions (overlapping-detection stimulus) and zero-filled gaps.
- Used in self-checking loopback and on-chip BIST of sequence detectors.

Parameters:
- PATTERN_W, 4, pattern length in bits (>=2).
- CNT_W, 4, repetition counter width; max reps = 2^CNT_W-1.
- GAP_W, 3, gap length width; max gap = 2^GAP_W-1 zero bits.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a transmission.
- pattern  input  PATTERN_W  bits to send, bit PATTERN_W-1 first.
- reps  input  CNT_W  number of pattern repetitions.
- gap  input  GAP_W  zero bits inserted between repetitions.
- ready  output  1  high only in IDLE; start is accepted only then.
- busy  output  1  high in SHIFT, GAP and PAR states.
- o  output  1  serial data bit, registered.
- o_valid  output  1  o carries a stream bit this cycle.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: while rst is high at a rising edge the block goes to IDLE with o=0, o_valid=0, busy=0, done=0, ready=1, and all counters cleared.
- rst overrides start and any in-flight transfer. Reset mid-stream aborts immediately with no done pulse.
- All outputs are registered; no combinational input-to-output path.
- States: IDLE, SHIFT, GAP, PAR (optional), DONE.
- IDLE:
  - start=1 and reps!=0 at an edge: capture pattern, reps and gap; bit_idx=PATTERN_W-1; rep_left=reps; next state SHIFT.
  - start=1 with reps=0: ignored, stay IDLE, no done.
- SHIFT:
  - o=pattern_q[bit_idx], o_valid=1.
  - Latency: the first bit is on o in the first cycle after the accepting edge.
  - On bit_idx=0: rep_left decrements.
    - If rep_left was 1: go to DONE.
    - Else if gap_q!=0: go to GAP.
    - Else: go to SHIFT with bit_idx reloaded, no dead cycle (back-to-back patterns).
- GAP:
  - o=0, o_valid=1 for exactly gap_q cycles; the gap zeros are real stream bits.
  - Then SHIFT with bit_idx reloaded.
- DONE:
  - o=0, o_valid=0, done=1 for exactly one cycle, ready=0; next state IDLE.
- start while not IDLE is ignored. Input changes after capture have no effect.
- Transfer length from accept to done, in valid cycles: reps*PATTERN_W + (reps-1)*gap (+reps with parity). done follows in the next cycle; ready rises the cycle after done.
- Counters never wrap. reps=2^CNT_W-1 and gap=2^GAP_W-1 must work exactly.

Optional Feature:
- Macro: SEQ_PATTERN_GEN_PARITY_EN.
- Defined: state PAR follows each pattern's last bit and emits one even-parity bit (XOR of pattern_q) with o_valid=1. After PAR the GAP/SHIFT/DONE decision applies.
- Undefined: PAR state and parity logic are absent; SHIFT goes directly to the next-state decision.

Test Plan:
1. Reset check: hold rst=1 for 2 cycles with start=1, pattern=4'b1101, reps=1 -> o=0, o_valid=0, ready=1, busy=0, done=0; no transfer starts after rst drops.
2. Single pattern: pattern=1101, reps=1, gap=0 -> o=1,1,0,1 on cycles 1-4 after accept with o_valid=1; done=1 on cycle 5; ready=1 on cycle 6. A connected moore detector's o rises after the 4th bit.
3. Overlap stream: pattern=1101, reps=2, gap=0 -> 8 contiguous valid bits 11011101, done on cycle 9. The detector fires twice.
4. Gapped stream: pattern=1101, reps=3, gap=2 -> 16 valid bits 1101 00 1101 00 1101, done on cycle 17.
5. Protocol:
   - start with reps=0 -> no busy, no done.
   - start pulse with pattern=0000 during the scenario-3 transfer -> stream unchanged.
6. Mid-stream reset: rst=1 during cycle 3 of scenario 2 -> next cycle o=0, o_valid=0, IDLE, no done. A new start is accepted afterwards and completes normally.
   - With SEQ_PATTERN_GEN_PARITY_EN: pattern=1101, reps=2, gap=1 -> 1101 1 0 1101 1 (11 valid bits).
